// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//   Shared constants and types for the fetch stage and its branch target
//   buffer: the NOP encoding used for pipeline bubbles, the 2-bit counter
//   reset/allocation values, the IF/ID register record and the saturating
//   counter helper.
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  // ADDI x0, x0, 0 -- what ID sees whenever IF/ID holds a bubble.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Counter value of every BTB entry after reset (weakly not-taken).
  localparam logic [1:0] CTR_RESET = 2'b01;

  // Counter value of a freshly allocated entry (weakly taken).
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        predTaken;
    logic [31:0] predTarget;
  } ifIdReg_t;

  localparam ifIdReg_t IF_ID_BUBBLE = '{
    inst:       NOP_INST,
    pc:         32'h0,
    valid:      1'b0,
    predTaken:  1'b0,
    predTarget: 32'h0
  };

  // Two-bit saturating counter step: never wraps past 00 or 11.
  function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_btb.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//   Direct-mapped BTB with 2-bit direction counters. Lookup is purely
//   combinational; training is applied on the rising clock edge. Addresses
//   are supplied as word addresses (byte address bits [31:2]).
//
//   clk             in   clock
//   reset           in   asynchronous, active-low
//   i_lookupWord    in   word address being fetched
//   o_predTaken     out  entry valid, tag matches, counter MSB set
//   o_predTarget    out  stored target of the indexed entry
//   i_updateEn      in   train the entry selected by i_updateWord
//   i_updateWord    in   word address of the resolved instruction
//   i_updateTaken   in   resolved direction
//   i_updateTarget  in   resolved taken target
// ---------------------------------------------------------------------------
module branch_target_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ENTRIES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] i_lookupWord,
  output logic        o_predTaken,
  output logic [31:0] o_predTarget,
  input  logic        i_updateEn,
  input  logic [29:0] i_updateWord,
  input  logic        i_updateTaken,
  input  logic [31:0] i_updateTarget
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lkIdx;
  logic [IDX_W-1:0] w_upIdx;
  logic [TAG_W-1:0] w_lkTag;
  logic [TAG_W-1:0] w_upTag;
  logic             w_lkHit;
  logic             w_upHit;

  assign w_lkIdx = i_lookupWord[IDX_W-1:0];
  assign w_lkTag = i_lookupWord[29:IDX_W];
  assign w_upIdx = i_updateWord[IDX_W-1:0];
  assign w_upTag = i_updateWord[29:IDX_W];

  assign w_lkHit = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
  assign w_upHit = r_valid[w_upIdx] && (r_tag[w_upIdx] == w_upTag);

  // Lookup reads the arrays before this edge's training lands, so a
  // same-cycle lookup and update of one entry sees the old contents.
  assign o_predTaken  = w_lkHit && r_ctr[w_lkIdx][1];
  assign o_predTarget = r_target[w_lkIdx];

  // Training: a hit moves the counter, a taken miss replaces the entry,
  // a not-taken miss leaves the table untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (i_updateEn) begin
      if (w_upHit) begin
        r_ctr[w_upIdx] <= ctrStep(r_ctr[w_upIdx], i_updateTaken);
        if (i_updateTaken) begin
          r_target[w_upIdx] <= i_updateTarget;
        end
      end else if (i_updateTaken) begin
        r_valid[w_upIdx]  <= 1'b1;
        r_tag[w_upIdx]    <= w_upTag;
        r_target[w_upIdx] <= i_updateTarget;
        r_ctr[w_upIdx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   IF stage plus IF/ID register. Holds the PC, drives the (combinational)
//   instruction memory address, predicts the next PC through the BTB and
//   honours EX redirects, ecall halt and hazard stalls.
//
//   clk, reset (async active-low)
//   is_stall / is_halted             hold PC and IF/ID
//   imem_addr / imem_dout            instruction memory interface
//   ex_mispredict / ex_correct_pc    redirect and flush
//   ex_update_en, ex_pc, ex_taken, ex_target   BTB training from EX
//   if_id_*                          IF/ID register outputs to ID
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          BTB_ENTRIES = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stall,
  input  logic        is_halted,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_correct_pc,
  input  logic        ex_update_en,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target
);

  logic [31:0] r_pc;
  ifIdReg_t    r_ifId;

  logic        w_predTaken;
  logic [31:0] w_btbTarget;
  logic [31:0] w_predNext;
  logic        w_unusedExPcLow;

  // Instructions are word aligned; the byte offset of ex_pc carries no
  // information for the BTB.
  assign w_unusedExPcLow = ^ex_pc[1:0];

  branch_target_buffer #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk            (clk),
    .reset          (reset),
    .i_lookupWord   (r_pc[31:2]),
    .o_predTaken    (w_predTaken),
    .o_predTarget   (w_btbTarget),
    .i_updateEn     (ex_update_en),
    .i_updateWord   (ex_pc[31:2]),
    .i_updateTaken  (ex_taken),
    .i_updateTarget (ex_target)
  );

  assign w_predNext = w_predTaken ? w_btbTarget : r_pc + 32'd4;

  // PC and IF/ID advance together. A redirect wins over halt and stall;
  // halt and stall simply hold both, so the held PC refetches the same
  // instruction next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_ifId <= IF_ID_BUBBLE;
    end else if (ex_mispredict) begin
      r_pc   <= ex_correct_pc;
      r_ifId <= IF_ID_BUBBLE;
    end else if (!is_halted && !is_stall) begin
      r_pc              <= w_predNext;
      r_ifId.inst       <= imem_dout;
      r_ifId.pc         <= r_pc;
      r_ifId.valid      <= 1'b1;
      r_ifId.predTaken  <= w_predTaken;
      r_ifId.predTarget <= w_predNext;
    end
  end

  assign imem_addr         = r_pc;
  assign if_id_inst        = r_ifId.inst;
  assign if_id_pc          = r_ifId.pc;
  assign if_id_valid       = r_ifId.valid;
  assign if_id_pred_taken  = r_ifId.predTaken;
  assign if_id_pred_target = r_ifId.predTarget;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed vector table, hand-written BTB / reset sequences and a random
//   run, all compared against a behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int N = 32;

  logic        clk;
  logic        reset;
  logic        isStall;
  logic        isHalted;
  logic [31:0] imemAddr;
  logic [31:0] imemDout;
  logic        exMispredict;
  logic [31:0] exCorrectPc;
  logic        exUpdateEn;
  logic [31:0] exPc;
  logic        exTaken;
  logic [31:0] exTarget;
  logic [31:0] ifIdInst;
  logic [31:0] ifIdPc;
  logic        ifIdValid;
  logic        ifIdPredTaken;
  logic [31:0] ifIdPredTarget;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] mPc;
  logic [31:0] mInst;
  logic [31:0] mIfPc;
  logic        mValid;
  logic        mPredTaken;
  logic [31:0] mPredTarget;
  bit          mbValid [N];
  logic [31:0] mbTag   [N];
  logic [31:0] mbTgt   [N];
  int          mbCtr   [N];

  instruction_fetch_unit #(
    .BTB_ENTRIES (N),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .is_stall          (isStall),
    .is_halted         (isHalted),
    .imem_addr         (imemAddr),
    .imem_dout         (imemDout),
    .ex_mispredict     (exMispredict),
    .ex_correct_pc     (exCorrectPc),
    .ex_update_en      (exUpdateEn),
    .ex_pc             (exPc),
    .ex_taken          (exTaken),
    .ex_target         (exTarget),
    .if_id_inst        (ifIdInst),
    .if_id_pc          (ifIdPc),
    .if_id_valid       (ifIdValid),
    .if_id_pred_taken  (ifIdPredTaken),
    .if_id_pred_target (ifIdPredTarget)
  );

  // Instruction memory: an ADDI x1,x1,imm whose immediate encodes the address
  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[13:2], 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  assign imemDout = instOf(imemAddr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model reset
  task automatic modelReset();
    mPc = 32'h0; mInst = 32'h13; mIfPc = 32'h0; mValid = 1'b0;
    mPredTaken = 1'b0; mPredTarget = 32'h0;
    for (int i = 0; i < N; i++) begin
      mbValid[i] = 1'b0; mbTag[i] = 32'h0; mbTgt[i] = 32'h0; mbCtr[i] = 1;
    end
  endtask

  // One clock edge of the model, using the inputs currently driven
  task automatic modelEdge();
    int          idx;
    int          uIdx;
    logic [31:0] tag;
    logic [31:0] uTag;
    logic        pt;
    logic [31:0] pn;
    idx = int'((mPc / 4) % N);
    tag = mPc / (4 * N);
    pt  = mbValid[idx] && (mbTag[idx] == tag) && (mbCtr[idx] >= 2);
    pn  = pt ? mbTgt[idx] : mPc + 32'd4;
    if (exUpdateEn) begin
      uIdx = int'((exPc / 4) % N);
      uTag = exPc / (4 * N);
      if (mbValid[uIdx] && mbTag[uIdx] == uTag) begin
        if (exTaken) begin
          mbCtr[uIdx] = (mbCtr[uIdx] < 3) ? mbCtr[uIdx] + 1 : 3;
          mbTgt[uIdx] = exTarget;
        end else begin
          mbCtr[uIdx] = (mbCtr[uIdx] > 0) ? mbCtr[uIdx] - 1 : 0;
        end
      end else if (exTaken) begin
        mbValid[uIdx] = 1'b1; mbTag[uIdx] = uTag; mbTgt[uIdx] = exTarget; mbCtr[uIdx] = 2;
      end
    end
    if (exMispredict) begin
      mPc = exCorrectPc; mInst = 32'h13; mIfPc = 32'h0; mValid = 1'b0;
      mPredTaken = 1'b0; mPredTarget = 32'h0;
    end else if (!isHalted && !isStall) begin
      mInst = instOf(mPc); mIfPc = mPc; mValid = 1'b1;
      mPredTaken = pt; mPredTarget = pn; mPc = pn;
    end
  endtask

  // Single comparison
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic checkModel(input string tag);
    checkOutput({tag, ".imem_addr"}, imemAddr, mPc);
    checkOutput({tag, ".valid"}, {31'b0, ifIdValid}, {31'b0, mValid});
    checkOutput({tag, ".inst"}, ifIdInst, mInst);
    checkOutput({tag, ".predTaken"}, {31'b0, ifIdPredTaken}, {31'b0, mPredTaken});
    checkOutput({tag, ".predTarget"}, ifIdPredTarget, mPredTarget);
    if (mValid) checkOutput({tag, ".pc"}, ifIdPc, mIfPc);
  endtask

  task automatic setIdle();
    isStall = 0; isHalted = 0; exMispredict = 0; exCorrectPc = 0;
    exUpdateEn = 0; exPc = 0; exTaken = 0; exTarget = 0;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare
  task automatic applyStimulus(input bit stall, input bit halt, input bit mis,
                               input logic [31:0] cpc, input bit upd,
                               input logic [31:0] epc, input bit et,
                               input logic [31:0] etgt, input string tag);
    isStall = stall; isHalted = halt; exMispredict = mis; exCorrectPc = cpc;
    exUpdateEn = upd; exPc = epc; exTaken = et; exTarget = etgt;
    @(posedge clk);
    modelEdge();
    #1;
    checkModel(tag);
  endtask

  // Hold reset across an edge, check reset values, release off-edge
  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    setIdle();
    modelReset();
    @(negedge clk);
    checkOutput("rst.imem_addr", imemAddr, 32'h0);
    checkOutput("rst.valid", {31'b0, ifIdValid}, 32'h0);
    checkOutput("rst.inst", ifIdInst, 32'h13);
    checkOutput("rst.pc", ifIdPc, 32'h0);
    checkOutput("rst.predTaken", {31'b0, ifIdPredTaken}, 32'h0);
    checkOutput("rst.predTarget", ifIdPredTarget, 32'h0);
    reset = 1'b1;
  endtask

  typedef struct {
    bit          stall;
    bit          halt;
    bit          mis;
    logic [31:0] cpc;
    logic [31:0] expAddr;
    logic [31:0] expIfPc;
    bit          expValid;
  } vec_t;

  vec_t vecs [10];

  initial begin
    reset = 1'b0;
    setIdle();
    modelReset();

    vecs[0] = '{0, 0, 0, 32'h0,  32'h4,  32'h0,  1};
    vecs[1] = '{0, 0, 0, 32'h0,  32'h8,  32'h4,  1};
    vecs[2] = '{1, 0, 0, 32'h0,  32'h8,  32'h4,  1};
    vecs[3] = '{1, 0, 0, 32'h0,  32'h8,  32'h4,  1};
    vecs[4] = '{0, 0, 0, 32'h0,  32'hC,  32'h8,  1};
    vecs[5] = '{1, 0, 1, 32'h40, 32'h40, 32'h0,  0};
    vecs[6] = '{0, 0, 0, 32'h0,  32'h44, 32'h40, 1};
    vecs[7] = '{0, 1, 0, 32'h0,  32'h44, 32'h40, 1};
    vecs[8] = '{1, 1, 0, 32'h0,  32'h44, 32'h40, 1};
    vecs[9] = '{0, 0, 0, 32'h0,  32'h48, 32'h44, 1};

    // Directed table: sequential fetch, stall, redirect under stall, halt
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].halt, vecs[i].mis, vecs[i].cpc,
                    0, 0, 0, 0, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d.addr", i), imemAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d.valid", i), {31'b0, ifIdValid}, {31'b0, vecs[i].expValid});
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d.ifpc", i), ifIdPc, vecs[i].expIfPc);
      else
        checkOutput($sformatf("vec%0d.nop", i), ifIdInst, 32'h13);
    end

    // BTB training, prediction and counter decay
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 1, 32'h80, "train");
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, "redir10");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "fetch10");
    checkOutput("btb.predTaken", {31'b0, ifIdPredTaken}, 32'h1);
    checkOutput("btb.nextPc", imemAddr, 32'h80);
    checkOutput("btb.predTarget", ifIdPredTarget, 32'h80);
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 0, 0, "nt1");
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 0, 0, "nt2");
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, "redir10b");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "fetch10b");
    checkOutput("btbDecay.predTaken", {31'b0, ifIdPredTaken}, 32'h0);
    checkOutput("btbDecay.nextPc", imemAddr, 32'h14);

    // Aliasing: same index, different tag must miss
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 1, 32'h80, "aliasTrain");
    applyStimulus(0, 0, 1, 32'h10 + 4 * N, 0, 0, 0, 0, "aliasRedir");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "aliasFetch");
    checkOutput("alias.predTaken", {31'b0, ifIdPredTaken}, 32'h0);
    checkOutput("alias.nextPc", imemAddr, 32'h10 + 4 * N + 4);

    // Asynchronous reset mid-stream
    applyStimulus(0, 0, 0, 0, 1, 32'h10, 1, 32'h80, "midTrain");
    applyStimulus(0, 0, 1, 32'h24, 0, 0, 0, 0, "mid24");
    checkOutput("mid.pcBefore", imemAddr, 32'h24);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midRst.addr", imemAddr, 32'h0);
    checkOutput("midRst.valid", {31'b0, ifIdValid}, 32'h0);
    checkOutput("midRst.inst", ifIdInst, 32'h13);
    modelReset();
    setIdle();
    #3;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "postRst");
    checkOutput("postRst.ifpc", ifIdPc, 32'h0);
    checkOutput("postRst.addr", imemAddr, 32'h4);
    applyStimulus(0, 0, 1, 32'h10, 0, 0, 0, 0, "postRedir");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, "postFetch10");
    checkOutput("postRst.btbCleared", {31'b0, ifIdPredTaken}, 32'h0);
    checkOutput("postRst.nextPc", imemAddr, 32'h14);

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(3) == 0), ($urandom_range(49) == 0),
                    ($urandom_range(9) == 0), {22'b0, 8'($urandom), 2'b00},
                    ($urandom_range(2) == 0), {23'b0, 7'($urandom), 2'b00},
                    1'($urandom), {23'b0, 7'($urandom), 2'b00},
                    $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
